// File: rtl/audio_recorder_core.sv
// Record/playback engine between the codec sample strobes and the output mux.
// Modes: idle, pass-through, record into on-chip RAM, and playback (one-shot or looping).
module audio_recorder_core #(
  parameter int SAMPLE_W = 16,
  parameter int ADDR_W   = 14,
  parameter int NUM_CH   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   sample_end,
  input  logic [NUM_CH-1:0]   sample_req,
  input  logic [SAMPLE_W-1:0] audio_input,
  output logic [SAMPLE_W-1:0] audio_output,
  input  logic [1:0]          mode,
  input  logic                loop,
  input  logic [2:0]          vol_shift,
  output logic [1:0]          state,
  output logic [ADDR_W:0]     rec_len,
  output logic                full,
  output logic                play_done,
  output logic                overrun
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST_LEN = {1'b0, {ADDR_W{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PASS = 2'b01,
    S_REC  = 2'b10,
    S_PLAY = 2'b11
  } state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic [1:0]                 r_mode;
  logic [SAMPLE_W-1:0]        r_hold;
  logic [SAMPLE_W-1:0]        r_out;
  logic [SAMPLE_W-1:0]        r_mem_q;
  logic [SAMPLE_W-1:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0]          r_wr_ptr;
  logic [ADDR_W:0]            r_rd_ptr;
  logic [ADDR_W:0]            r_rec_len;
  logic                       r_full;
  logic                       r_play_done;
  logic                       r_overrun;
  logic                       r_rd_vld;

  logic                       w_end;
  logic                       w_req;
  logic                       w_multi;
  logic                       w_wr;
  logic                       w_rd;
  logic                       w_rd_last;
  logic                       w_enter_rec;
  logic                       w_enter_play;
  logic [ADDR_W:0]            w_rd_nxt;
  logic signed [SAMPLE_W-1:0] w_hold_s;
  logic signed [SAMPLE_W-1:0] w_mem_s;
  logic [SAMPLE_W-1:0]        w_hold_sh;
  logic [SAMPLE_W-1:0]        w_mem_sh;

  // x & (x-1) is non-zero exactly when more than one strobe bit is set.
  assign w_end     = |sample_end;
  assign w_req     = |sample_req;
  assign w_multi   = ((sample_end & (sample_end - 1'b1)) != '0) ||
                     ((sample_req & (sample_req - 1'b1)) != '0);
  assign w_wr      = (r_state == S_REC) && w_end && !r_full;
  assign w_rd      = (r_state == S_PLAY) && w_req && (r_rd_ptr < r_rec_len);
  assign w_rd_nxt  = r_rd_ptr + 1'b1;
  assign w_rd_last = (w_rd_nxt == r_rec_len);
  assign w_hold_s  = r_hold;
  assign w_mem_s   = r_mem_q;
  assign w_hold_sh = w_hold_s >>> vol_shift;
  assign w_mem_sh  = w_mem_s >>> vol_shift;

  always_comb begin
    w_state_next = state_t'(r_mode);
    w_enter_rec  = (w_state_next == S_REC) && (r_state != S_REC);
    w_enter_play = (w_state_next == S_PLAY) && (r_state != S_PLAY);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode  <= S_IDLE;
      r_state <= S_IDLE;
    end else begin
      r_mode  <= mode;
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold      <= '0;
      r_out       <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_rec_len   <= '0;
      r_full      <= 1'b0;
      r_play_done <= 1'b0;
      r_overrun   <= 1'b0;
      r_rd_vld    <= 1'b0;
    end else begin
      r_rd_vld <= 1'b0;
      if (w_multi) r_overrun <= 1'b1;
      if (w_end && (r_state == S_PASS || r_state == S_REC)) r_hold <= audio_input;
      if (r_rd_vld) r_out <= w_mem_sh;
      case (r_state)
        S_IDLE: if (w_req) r_out <= '0;
        S_PASS: if (w_req) r_out <= w_hold_sh;
        S_REC: begin
          if (w_req) r_out <= w_hold_sh;
          if (w_wr) begin
            r_wr_ptr  <= r_wr_ptr + 1'b1;
            r_rec_len <= r_rec_len + 1'b1;
            if (r_rec_len == LAST_LEN) r_full <= 1'b1;
          end
        end
        S_PLAY: begin
          // The sample itself lands two cycles later via r_rd_vld.
          if (w_rd) begin
            r_rd_vld <= 1'b1;
            r_rd_ptr <= (w_rd_last && loop) ? '0 : w_rd_nxt;
            if (w_rd_last && !loop) r_play_done <= 1'b1;
          end else if (w_req) begin
            r_out <= '0;
          end
        end
        default: ;
      endcase
      if (w_enter_rec) begin
        r_wr_ptr  <= '0;
        r_rec_len <= '0;
        r_full    <= 1'b0;
      end
      if (w_enter_play) begin
        r_rd_ptr    <= '0;
        r_play_done <= (r_rec_len == '0);
      end
    end
  end

  // Reset-free so the array maps onto simple dual-port block RAM.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= audio_input;
    if (w_rd) r_mem_q <= r_mem[r_rd_ptr[ADDR_W-1:0]];
  end

  assign audio_output = r_out;
  assign state        = r_state;
  assign rec_len      = r_rec_len;
  assign full         = r_full;
  assign play_done    = r_play_done;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_audio_recorder_core.sv
// Bench for audio_recorder_core with a 16-sample buffer: directed ramps plus randomized
// record/playback compared against a queue-based model of the recorder.
module tb_audio_recorder_core;

  localparam int SW = 16;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    sample_end = '0;
  logic [1:0]    sample_req = '0;
  logic [SW-1:0] audio_input = '0;
  logic [SW-1:0] audio_output;
  logic [1:0]    mode = 2'b00;
  logic          loop = 1'b0;
  logic [2:0]    vol_shift = '0;
  logic [1:0]    state;
  logic [AW:0]   rec_len;
  logic          full;
  logic          play_done;
  logic          overrun;

  audio_recorder_core #(.SAMPLE_W(SW), .ADDR_W(AW), .NUM_CH(2)) dut (
    .clk(clk), .reset(reset), .sample_end(sample_end), .sample_req(sample_req),
    .audio_input(audio_input), .audio_output(audio_output), .mode(mode), .loop(loop),
    .vol_shift(vol_shift), .state(state), .rec_len(rec_len), .full(full),
    .play_done(play_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: recorded samples as a queue, playback index, hold value.
  int          m_mem[$];
  int          m_idx  = 0;
  bit          m_done = 0;
  logic [1:0]  m_cur  = 2'b00;
  logic [15:0] m_hold = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Arithmetic right shift expressed as floor division.
  function automatic logic [15:0] scale(input logic [15:0] d, input int sh);
    int v;
    int p;
    v = int'($signed(d));
    p = 1 << sh;
    if (v >= 0) v = v / p;
    else v = -((-v + p - 1) / p);
    return v[15:0];
  endfunction

  task automatic set_mode(input logic [1:0] m);
    mode = m;
    tick();
    tick();
    check("state", {30'd0, state}, {30'd0, m});
    tick();
    if (m != m_cur) begin
      if (m == 2'b10) m_mem.delete();
      if (m == 2'b11) begin
        m_idx  = 0;
        m_done = (m_mem.size() == 0);
      end
    end
    m_cur = m;
  endtask

  task automatic send_end(input logic [1:0] vec, input logic [15:0] d);
    sample_end  = vec;
    audio_input = d;
    tick();
    sample_end = '0;
    tick();
    if (m_cur == 2'b01 || m_cur == 2'b10) m_hold = d;
    if (m_cur == 2'b10 && m_mem.size() < DEPTH) m_mem.push_back(int'(d));
  endtask

  task automatic send_req(input int ch, input string tag);
    logic [15:0] exp;
    sample_req = 2'(1 << ch);
    tick();
    sample_req = '0;
    tick();
    tick();
    exp = '0;
    case (m_cur)
      2'b01, 2'b10: exp = scale(m_hold, int'(vol_shift));
      2'b11: if (m_idx < m_mem.size()) begin
        exp = scale(16'(m_mem[m_idx]), int'(vol_shift));
        m_idx++;
        if (m_idx == m_mem.size()) begin
          if (loop) m_idx = 0;
          else m_done = 1;
        end
      end
      default: exp = '0;
    endcase
    check(tag, {16'd0, audio_output}, {16'd0, exp});
  endtask

  initial begin
    int n;
    // T1: reset with strobes active
    sample_end = '1;
    sample_req = '1;
    audio_input = 16'h7FFF;
    repeat (3) tick();
    check("rst_out", {16'd0, audio_output}, 32'd0);
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_len", {27'd0, rec_len}, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_done", {31'd0, play_done}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    sample_end = '0;
    sample_req = '0;
    tick();
    reset = 1'b1;
    tick();
    // T2: pass-through
    set_mode(2'b01);
    send_end(2'b10, 16'h1234);
    send_req(1, "pass_1234");
    vol_shift = 3'd2;
    send_end(2'b01, 16'h8000);
    send_req(0, "pass_8000_sh2");
    check("pass_E000", {16'd0, audio_output}, 32'h0000E000);
    for (int i = 0; i < 8; i++) begin
      vol_shift = 3'($urandom_range(0, 7));
      send_end(2'($urandom_range(1, 2)), 16'($urandom));
      send_req($urandom_range(0, 1), "pass_rand");
    end
    // T3: record ramp until full
    vol_shift = '0;
    set_mode(2'b10);
    for (int i = 1; i <= 20; i++) send_end(2'b01, 16'(i));
    check("rec_len16", {27'd0, rec_len}, 32'd16);
    check("rec_full", {31'd0, full}, 32'd1);
    // T4: one-shot playback
    set_mode(2'b00);
    loop = 1'b0;
    set_mode(2'b11);
    for (int i = 1; i <= 18; i++) begin
      send_req(0, "play_once");
      if (i == 15) check("done_early", {31'd0, play_done}, 32'd0);
      if (i == 16) check("done_16", {31'd0, play_done}, 32'd1);
    end
    // T5: looping playback
    set_mode(2'b00);
    loop = 1'b1;
    set_mode(2'b11);
    for (int i = 0; i < 34; i++) send_req(i % 2, "play_loop");
    check("loop_nodone", {31'd0, play_done}, 32'd0);
    set_mode(2'b10);
    set_mode(2'b00);
    set_mode(2'b11);
    check("empty_done", {31'd0, play_done}, 32'd1);
    send_req(0, "empty_out");
    check("ovr_before", {31'd0, overrun}, 32'd0);
    set_mode(2'b01);
    send_end(2'b11, 16'h0BAD);
    check("ovr_set", {31'd0, overrun}, 32'd1);
    send_req(0, "ovr_hold");
    // T6: reset mid-play
    set_mode(2'b10);
    for (int i = 0; i < 10; i++) send_end(2'b01, 16'($urandom));
    set_mode(2'b00);
    loop = 1'b0;
    set_mode(2'b11);
    for (int i = 0; i < 7; i++) send_req(0, "pre_reset");
    reset = 1'b0;
    tick();
    check("mid_rst_len", {27'd0, rec_len}, 32'd0);
    check("mid_rst_state", {30'd0, state}, 32'd0);
    check("mid_rst_out", {16'd0, audio_output}, 32'd0);
    check("mid_rst_ovr", {31'd0, overrun}, 32'd0);
    m_mem.delete();
    m_cur = 2'b00;
    reset = 1'b1;
    set_mode(2'b11);
    check("after_rst_done", {31'd0, play_done}, 32'd1);
    send_req(1, "after_rst_out");
    // Randomized record/playback rounds
    for (int r = 0; r < 4; r++) begin
      set_mode(2'b10);
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) send_end(2'($urandom_range(1, 2)), 16'($urandom));
      check("rnd_len", {27'd0, rec_len}, 32'(m_mem.size()));
      check("rnd_full", {31'd0, full}, {31'd0, (m_mem.size() == DEPTH)});
      set_mode(2'b00);
      loop = 1'($urandom_range(0, 1));
      vol_shift = 3'($urandom_range(0, 7));
      set_mode(2'b11);
      for (int i = 0; i < 2 * m_mem.size() + 3; i++) send_req($urandom_range(0, 1), "rnd_play");
      check("rnd_done", {31'd0, play_done}, {31'd0, m_done});
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
